// File: rtl/mem_responder.sv
// mem_responder: 256 x 8 single-port memory serving a strobe-based request interface.
// Defining MEM_LOADER_EN adds a byte-stream loader that fills memory before the controller runs.
module mem_responder #(
   parameter int DEPTH     = 256,
   parameter bit INIT_ZERO = 1'b0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] address,
   input  logic [7:0] to_mem,
   input  logic       mem_write,
   input  logic       mem_clock,
   output logic [7:0] from_mem,
   output logic       mem_ready
`ifdef MEM_LOADER_EN
   ,
   input  logic       load_valid,
   input  logic [7:0] load_data,
   output logic       load_ready
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       strobe_q, strobe_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic       wr_q, wr_d;
   logic       mem_ready_q, mem_ready_d;
   logic [7:0] from_mem_q;
   logic       req;
   logic       capture;
   logic       access_wr;
   logic       access_rd;
   logic       mem_we;
   logic [7:0] mem_waddr;
   logic [7:0] mem_wdata;
   logic       rd_en;

   // The strobe is an ordinary synchronous input; only its rising edge requests an access.
   assign req = mem_clock & ~strobe_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (req) state_d = S_ACCESS;
         S_ACCESS: state_d = S_DONE;
         S_DONE:   if (!mem_clock) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      capture     = 1'b0;
      mem_ready_d = 1'b0;
      access_wr   = 1'b0;
      access_rd   = 1'b0;
      case (state_q)
         S_IDLE:   capture = req;
         S_ACCESS: begin
            mem_ready_d = 1'b1;
            access_wr   = wr_q;
            access_rd   = ~wr_q;
         end
         S_DONE:   mem_ready_d = mem_clock;
         default:  mem_ready_d = 1'b0;
      endcase
   end

   always_comb begin
      strobe_d = mem_clock;
      addr_d   = capture ? address   : addr_q;
      data_d   = capture ? to_mem    : data_q;
      wr_d     = capture ? mem_write : wr_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         strobe_q    <= 1'b1;
         addr_q      <= 8'h00;
         data_q      <= 8'h00;
         wr_q        <= 1'b0;
         mem_ready_q <= 1'b0;
      end else begin
         strobe_q    <= strobe_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         wr_q        <= wr_d;
         mem_ready_q <= mem_ready_d;
      end
   end

`ifdef MEM_LOADER_EN
   logic [7:0] load_ptr_q, load_ptr_d;
   logic       load_accept;

   // A controller request in the same cycle wins; the source simply holds its byte.
   assign load_ready  = (state_q == S_IDLE) & ~req;
   assign load_accept = load_valid & load_ready & ~reset;

   always_comb begin
      load_ptr_d = load_accept ? load_ptr_q + 8'd1 : load_ptr_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         load_ptr_q <= 8'h00;
      end else begin
         load_ptr_q <= load_ptr_d;
      end
   end
`endif

   // Controller writes and loader writes are never simultaneous (loader needs IDLE), so one port suffices.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      mem_wdata = data_q;
      if (!reset && access_wr) begin
         mem_we = 1'b1;
      end
`ifdef MEM_LOADER_EN
      else if (load_accept) begin
         mem_we    = 1'b1;
         mem_waddr = load_ptr_q;
         mem_wdata = load_data;
      end
`endif
   end

   assign rd_en = ~reset & access_rd;

   if (INIT_ZERO) begin : g_mem_zero
      logic [7:0] mem_q [DEPTH] = '{default: 8'h00};

      always_ff @(posedge clock) begin
         if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            from_mem_q <= 8'h00;
         end else if (rd_en) begin
            from_mem_q <= mem_q[addr_q];
         end
      end
   end else begin : g_mem_x
      logic [7:0] mem_q [DEPTH];

      always_ff @(posedge clock) begin
         if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
         end
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            from_mem_q <= 8'h00;
         end else if (rd_en) begin
            from_mem_q <= mem_q[addr_q];
         end
      end
   end

   assign from_mem  = from_mem_q;
   assign mem_ready = mem_ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: reference memory model plus a read-data scoreboard queue.
// Loader scenarios are included when MEM_LOADER_EN is defined.
module tb_mem_responder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] address = 8'h00;
   logic [7:0] to_mem = 8'h00;
   logic       mem_write = 1'b0;
   logic       mem_clock = 1'b0;
   logic [7:0] from_mem;
   logic       mem_ready;
`ifdef MEM_LOADER_EN
   logic       load_valid = 1'b0;
   logic [7:0] load_data = 8'h00;
   logic       load_ready;
`endif

   int         vectors_applied = 0;
   int         miscompares = 0;
   logic [7:0] model_mem [256];
   logic [7:0] sb_q [$];
   logic [7:0] exp_rd = 8'h00;

   always #5 clock = ~clock;

   mem_responder dut (
      .clock     (clock),
      .reset     (reset),
      .address   (address),
      .to_mem    (to_mem),
      .mem_write (mem_write),
      .mem_clock (mem_clock),
      .from_mem  (from_mem),
      .mem_ready (mem_ready)
`ifdef MEM_LOADER_EN
      ,
      .load_valid(load_valid),
      .load_data (load_data),
      .load_ready(load_ready)
`endif
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      exp_rd = 8'h00;
   endtask

   // One strobe access; high_cycles counts posedges that sample the strobe high (>= 2).
   task automatic do_access(input logic [7:0] a, input logic [7:0] d, input logic wr,
                            input int high_cycles, input bit use_alt, input logic [7:0] alt_addr);
      address   = a;
      to_mem    = d;
      mem_write = wr;
      mem_clock = 1'b1;
      if (wr) model_mem[a] = d;
      else    sb_q.push_back(model_mem[a]);
      tick();
      check("rdy_at_req", 16'(mem_ready), 16'd0);
      if (use_alt) begin
         address   = alt_addr;
         to_mem    = ~d;
         mem_write = ~wr;
      end
      tick();
      check("rdy_after_access", 16'(mem_ready), 16'd1);
      if (!wr) exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
      check("from_mem", 16'(from_mem), 16'(exp_rd));
      for (int i = 2; i < high_cycles; i++) begin
         tick();
         check("rdy_hold", 16'(mem_ready), 16'd1);
         check("from_mem_hold", 16'(from_mem), 16'(exp_rd));
      end
      mem_clock = 1'b0;
      tick();
      check("rdy_drop", 16'(mem_ready), 16'd0);
      $display("access %s addr=%02h data=%02h from_mem=%02h high=%0d",
               wr ? "WR" : "RD", a, wr ? d : exp_rd, from_mem, high_cycles);
   endtask

   initial begin
      do_reset();
      check("reset_from_mem", 16'(from_mem), 16'h0000);
      check("reset_rdy", 16'(mem_ready), 16'd0);
`ifdef MEM_LOADER_EN
      check("reset_ld_rdy", 16'(load_ready), 16'd1);
`endif
      tick();

      // Basic write / read-back with a 3-cycle strobe
      do_access(8'h10, 8'hA5, 1'b1, 3, 1'b0, 8'h00);
      do_access(8'h10, 8'h00, 1'b0, 3, 1'b0, 8'h00);

      // Strobe held 10 cycles: one access, stable outputs
      do_access(8'h20, 8'h77, 1'b1, 2, 1'b0, 8'h00);
      do_access(8'h20, 8'h00, 1'b0, 10, 1'b0, 8'h00);

      // Request fields changing after capture have no effect
      do_access(8'h30, 8'h5A, 1'b1, 2, 1'b0, 8'h00);
      do_access(8'h10, 8'h00, 1'b0, 3, 1'b1, 8'h30);
      do_access(8'h31, 8'hC3, 1'b1, 3, 1'b1, 8'h32);
      do_access(8'h31, 8'h00, 1'b0, 2, 1'b0, 8'h00);

      // Top address
      do_access(8'hFF, 8'h81, 1'b1, 2, 1'b0, 8'h00);
      do_access(8'hFF, 8'h00, 1'b0, 2, 1'b0, 8'h00);

      // Reset during the ACCESS cycle of a write suppresses the write
      do_access(8'h40, 8'h99, 1'b1, 2, 1'b0, 8'h00);
      address   = 8'h40;
      to_mem    = 8'h3C;
      mem_write = 1'b1;
      mem_clock = 1'b1;
      tick();
      reset     = 1'b1;
      mem_clock = 1'b0;
      tick();
      check("rst_acc_rdy", 16'(mem_ready), 16'd0);
      check("rst_acc_from_mem", 16'(from_mem), 16'h0000);
      tick();
      reset  = 1'b0;
      exp_rd = 8'h00;
      tick();
      do_access(8'h40, 8'h00, 1'b0, 2, 1'b0, 8'h00);

      // Strobe held high across reset release is not a request
      do_access(8'h50, 8'h12, 1'b1, 2, 1'b0, 8'h00);
      address   = 8'h50;
      to_mem    = 8'hEE;
      mem_write = 1'b1;
      mem_clock = 1'b1;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         check("held_strobe_rdy", 16'(mem_ready), 16'd0);
         check("held_strobe_from_mem", 16'(from_mem), 16'(exp_rd));
      end
      mem_clock = 1'b0;
      tick();
      do_access(8'h50, 8'h00, 1'b0, 2, 1'b0, 8'h00);

`ifdef MEM_LOADER_EN
      begin
         int         idx = 0;
         int         cyc = 0;
         int         ptr = 0;
         int         strobe_cnt = 0;
         bit         collided = 1'b0;
         logic       acc;
         logic [7:0] byte_v;
         load_valid = 1'b1;
         while (idx < 258 && cyc < 3000) begin
            byte_v    = (idx < 256) ? 8'(idx) : ((idx == 256) ? 8'h11 : 8'h22);
            load_data = byte_v;
            if (idx == 100 && !collided) begin
               collided   = 1'b1;
               address    = 8'h05;
               mem_write  = 1'b0;
               mem_clock  = 1'b1;
               sb_q.push_back(model_mem[8'h05]);
               strobe_cnt = 1;
            end
            @(negedge clock);
            if (strobe_cnt == 1) check("ld_rdy_on_req", 16'(load_ready), 16'd0);
            acc = load_ready;
            tick();
            if (acc) begin
               model_mem[8'(ptr)] = byte_v;
               $display("load ptr=%02h data=%02h", 8'(ptr), byte_v);
               ptr = (ptr + 1) % 256;
               idx++;
            end
            if (strobe_cnt > 0) begin
               strobe_cnt++;
               if (strobe_cnt == 3) begin
                  exp_rd = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                  check("ld_coll_rdy", 16'(mem_ready), 16'd1);
                  check("ld_coll_from_mem", 16'(from_mem), 16'(exp_rd));
                  mem_clock = 1'b0;
               end else if (strobe_cnt == 4) begin
                  strobe_cnt = 0;
               end
            end
            cyc++;
         end
         load_valid = 1'b0;
         check("ld_bytes_accepted", 16'(idx), 16'd258);
         tick();
         check("ld_rdy_idle", 16'(load_ready), 16'd1);
         do_access(8'h00, 8'h00, 1'b0, 2, 1'b0, 8'h00);
         check("ld_wrap0", 16'(from_mem), 16'h0011);
         do_access(8'h01, 8'h00, 1'b0, 2, 1'b0, 8'h00);
         check("ld_wrap1", 16'(from_mem), 16'h0022);
         do_access(8'h64, 8'h00, 1'b0, 2, 1'b0, 8'h00);
         do_access(8'hFF, 8'h00, 1'b0, 2, 1'b0, 8'h00);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
